// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: PC generation, synchronous imem fetch and IF/ID register with skid-based stall and branch flush.
// Optional FETCH_PERF_CNT_EN adds saturating fetch_count / stall_count outputs.
module instruction_fetch_stage #(
    parameter int          PC_WIDTH  = 32,
    parameter int          PC_STEP   = 1,
    parameter logic [31:0] NOP_INSTR = 32'hF000_0000
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic [PC_WIDTH-1:0] imem_addr,
    output logic                imem_en,
    input  logic [31:0]         imem_data,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                halt,
    output logic [31:0]         instr_out,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic                instr_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         fetch_count,
    output logic [31:0]         stall_count
`endif
);
    localparam logic [1:0] BOOT   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                pend_q, pend_d;
    logic [PC_WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic [31:0]         skid_q, skid_d;
    logic [PC_WIDTH-1:0] skid_pc_q, skid_pc_d;
    logic                skid_valid_q, skid_valid_d;
    logic [31:0]         instr_q, instr_d;
    logic [PC_WIDTH-1:0] pc_out_q, pc_out_d;
    logic                valid_q, valid_d;

    assign imem_en     = (state_q == RUN) & ~stall & ~branch_taken & ~halt;
    assign imem_addr   = pc_q;
    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        pend_pc_d    = pend_pc_q;
        skid_d       = skid_q;
        skid_pc_d    = skid_pc_q;
        skid_valid_d = skid_valid_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        valid_d      = valid_q;
        if (state_q == BOOT) begin
            state_d = RUN;
        end else if (state_q == RUN && branch_taken) begin
            pc_d         = branch_target;
            pend_d       = 1'b0;
            skid_valid_d = 1'b0;
            instr_d      = NOP_INSTR;
            pc_out_d     = '0;
            valid_d      = 1'b0;
        end else begin
            // HALTED keeps draining through the same path; imem_en is already 0 there
            if (state_q == RUN && halt) state_d = HALTED;
            if (stall) begin
                if (pend_q) begin
                    skid_d       = imem_data;
                    skid_pc_d    = pend_pc_q;
                    skid_valid_d = 1'b1;
                end
                pend_d = 1'b0;
            end else begin
                instr_d      = skid_valid_q ? skid_q : pend_q ? imem_data : NOP_INSTR;
                pc_out_d     = skid_valid_q ? skid_pc_q : pend_q ? pend_pc_q : '0;
                valid_d      = skid_valid_q | pend_q;
                skid_valid_d = 1'b0;
                pend_d       = imem_en;
                pend_pc_d    = imem_en ? pc_q : pend_pc_q;
                pc_d         = imem_en ? pc_q + PC_WIDTH'(PC_STEP) : pc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= BOOT;
            pc_q         <= '0;
            pend_q       <= 1'b0;
            pend_pc_q    <= '0;
            skid_q       <= NOP_INSTR;
            skid_pc_q    <= '0;
            skid_valid_q <= 1'b0;
            instr_q      <= NOP_INSTR;
            pc_out_q     <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            pend_pc_q    <= pend_pc_d;
            skid_q       <= skid_d;
            skid_pc_q    <= skid_pc_d;
            skid_valid_q <= skid_valid_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
            valid_q      <= valid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;

    always_comb begin
        fetch_cnt_d = (imem_en && !(&fetch_cnt_q)) ? fetch_cnt_q + 32'd1 : fetch_cnt_q;
        stall_cnt_d = (state_q == RUN && stall && !branch_taken && !(&stall_cnt_q)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif
endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the vector core.
- Generates PC, drives a synchronous instruction memory (1-cycle read latency), and presents one 32-bit instruction per cycle to the instruction decoder.
- Honors stall from the hazard detection unit without losing the in-flight fetch (skid register).
- Honors branch redirect (VBNZ/VBENZ resolved downstream) by flushing with NOP bubbles.

Parameters:
PC_WIDTH, 32, width of PC and instruction memory address
PC_STEP, 1, PC increment per sequential fetch (word-addressed imem)
NOP_INSTR, 32'hF000_0000, bubble encoding (opcode 6'b111100)

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
imem_addr  output  PC_WIDTH  fetch address, equals pc_reg combinationally
imem_en  output  1  fetch request this cycle
imem_data  input  32  instruction returned one cycle after imem_en
stall  input  1  hold IF/ID register (from HDU)
branch_taken  input  1  redirect request, priority over stall
branch_target  input  PC_WIDTH  redirect address, sampled when branch_taken=1
halt  input  1  stop fetching until reset
instr_out  output  32  IF/ID instruction to decoder
pc_out  output  PC_WIDTH  PC of instr_out
instr_valid  output  1  instr_out is a real fetched instruction

Behaviour:
- Reset (async, reset_n=0): pc_reg=0, state=BOOT, pend=0, skid_valid=0, instr_out=NOP_INSTR, pc_out=0, instr_valid=0. imem_en=0 while reset_n=0 or in BOOT.
- FSM:
  - BOOT -> RUN at the first edge with reset_n=1.
  - RUN -> HALTED at any edge with halt=1 (unless branch_taken is also 1 that cycle; branch is applied and halt is re-evaluated next cycle).
  - HALTED is terminal until reset.
- imem_en = (state==RUN) & ~stall & ~branch_taken & ~halt; imem_addr = pc_reg always.
- Pending fetch tracking: pend/pend_pc mark that imem_data holds the instruction for pend_pc this cycle.
- Edge priority (RUN):
  1. branch_taken=1: pc_reg<=branch_target; pend<=0; skid_valid<=0; instr_out<=NOP_INSTR; instr_valid<=0; pc_out<=0.
  2. else stall=1:
     - IF/ID holds.
     - If pend=1, then skid<=imem_data, skid_pc<=pend_pc, skid_valid<=1.
     - pend<=0; pc_reg holds.
  3. else advance:
     - skid_valid=1: IF/ID<=skid/skid_pc, valid=1.
     - else pend=1: IF/ID<=imem_data/pend_pc, valid=1.
     - else: IF/ID<=NOP_INSTR, pc_out<=0, valid=0.
     - skid_valid<=0.
     - If imem_en: pend<=1, pend_pc<=pc_reg, pc_reg<=pc_reg+PC_STEP (wraps modulo 2^PC_WIDTH).
- Skid cannot overflow: imem_en=0 during stall, so at most one fetch is in flight.
- Latency:
  - First valid instruction (addr 0) reaches instr_out at the 2nd edge after BOOT exit.
  - After a branch edge, instr_out carries NOP (valid=0) for 2 edges, then imem[target] on the 3rd.
  - Stall release: the held instruction advances on the first non-stall edge with no bubble; instruction order is preserved.
- HALTED:
  - No new fetch issued.
  - IF/ID still drains: the skid, or an in-flight pend, advances on a non-stall edge.
  - Afterwards IF/ID loads NOP with valid=0.
  - stall is still honored.
- Simultaneous branch_taken and stall: branch wins; stall ignored that cycle.
- Reset mid-operation: all state is cleared immediately (asynchronous); in-flight data is discarded.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs fetch_count[31:0] (increments on each imem_en cycle) and stall_count[31:0] (increments each RUN cycle with stall=1 and branch_taken=0). Both counters reset to 0, saturate at 32'hFFFF_FFFF, and are cleared only by reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, imem[k]=32'hA800_0000+k, no stall/branch -> instr_out/pc_out = (A800_0000,0),(A800_0001,1),(A800_0002,2) on edges 2,3,4 after BOOT; instr_valid=1 from edge 2.
- Stall held 3 cycles while pc 5 in flight -> instr_out holds pc 4; imem_en=0 during stall; after release, pc 5 then pc 6 on consecutive edges, with no duplicate or loss.
- branch_taken=1, branch_target=0x40 while streaming -> 2 edges of instr_out=F000_0000 and valid=0, then pc_out=0x40 with imem[0x40]; imem_addr=0x40 the cycle after the branch edge.
- branch_taken and stall both 1 with skid_valid=1 -> skid discarded, pc_reg=target, IF/ID=NOP; the skid instruction never appears.
- halt=1 at pc 8 -> imem_en stays 0; instructions up to pc 7 drain, then instr_valid=0 permanently; branch_taken afterwards has no fetch effect.
- reset_n pulsed low mid-stall with skid_valid=1 -> outputs immediately NOP/0/0; the sequence restarts at pc 0. With FETCH_PERF_CNT_EN, both counters read 0 after reset.
